// File: rtl/lenet_pkg.sv
// Purpose: shared widths, Q16.16 constants and sign-extension helpers for the LeNet datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lenet_pkg;

    localparam int PROD_W     = 64;  // multiplier product width (Q32.32)
    localparam int ACC_W      = 72;  // 8 guard bits: 256 taps of any product cannot wrap
    localparam int OUT_W      = 32;  // Q16.16 result width
    localparam int FRAC_SHIFT = 16;  // Q32.32 -> Q16.16

    localparam logic signed [OUT_W-1:0] OUT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [OUT_W-1:0] OUT_MIN = 32'sh8000_0000;
    localparam logic signed [OUT_W-1:0] ONE     = 32'sh0001_0000;

    // One buffered result: clamp flag alongside the Q16.16 value.
    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] dat;
    } res_t;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] v);
        return {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_out(input logic signed [OUT_W-1:0] v);
        return {{(ACC_W-OUT_W){v[OUT_W-1]}}, v};
    endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Purpose: product-in / result-out bundle for mac_accum.
// Latency: n/a (wires only).
// Backpressure: out_ready throttles the result port; the product side has none.
//   master: multiplier + consumer side (drives prod*, bias, out_ready)
//   slave : mac_accum side (drives out_data, out_valid, out_sat, ovf_err)
interface mac_accum_if;
    import lenet_pkg::*;

    logic signed [PROD_W-1:0] prod;
    logic                     prod_valid;
    logic                     prod_last;
    logic signed [OUT_W-1:0]  bias;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sat;
    logic                     ovf_err;

    modport master (
        output prod, prod_valid, prod_last, bias, out_ready,
        input  out_data, out_valid, out_sat, ovf_err
    );

    modport slave (
        input  prod, prod_valid, prod_last, bias, out_ready,
        output out_data, out_valid, out_sat, ovf_err
    );

endinterface

// File: rtl/mac_accum_result_fifo.sv
// Purpose: 2-entry synchronous FIFO; head data comes straight from flops.
// Latency: push at edge N is visible at the head after edge N (empty case).
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
//   ports: push/push_dat (write), pop (read head), full, empty, head_dat
module result_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop & (cnt_q != 2'd0);
        // A pop frees the slot the simultaneous push lands in.
        do_push  = push & ((cnt_q != 2'd2) | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/mac_accum.sv
// Purpose: sum a frame of Q32.32 products, add bias, round/shift to Q16.16, saturate, optional ReLU.
// Latency: last tap at edge T -> result in the output buffer at edge T+3.
// Backpressure: none toward the multiplier; a result arriving at a full buffer is dropped and ovf_err latches.
//   ports: clk, rst_n (async, active low), io (slave side of mac_accum_if)
module mac_accum
    import lenet_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    mac_accum_if.slave  io
);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC_SHIFT - 1));

    // Stage 1: accumulator and frame capture
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic signed [OUT_W-1:0] bias_q, bias_d;
    logic                    s1_vld_q, s1_vld_d;
    logic signed [ACC_W-1:0] tap_sum;

    // Stage 2: bias + rounding constant
    logic signed [ACC_W-1:0] biased_q, biased_d;
    logic                    s2_vld_q, s2_vld_d;

    // Stage 3: requantized result
    res_t                    res_q, res_d;
    logic                    s3_vld_q, s3_vld_d;
    logic signed [ACC_W-1:0] q_full;
    logic signed [OUT_W-1:0] q_sat;
    logic                    q_clamped;

    // Output buffer
    res_t                    head;
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic                    ovf_q, ovf_d;

    always_comb begin
        acc_d    = acc_q;
        sum_d    = sum_q;
        bias_d   = bias_q;
        s1_vld_d = 1'b0;
        tap_sum  = acc_q + sext_prod(io.prod);
        if (io.prod_valid) begin
            if (io.prod_last) begin
                sum_d    = tap_sum;
                bias_d   = io.bias;
                s1_vld_d = 1'b1;
                acc_d    = '0;  // next frame may start on the following cycle
            end else begin
                acc_d = tap_sum;
            end
        end
    end

    always_comb begin
        s2_vld_d = s1_vld_q;
        biased_d = biased_q;
        if (s1_vld_q) begin
            // Adding half an LSB before the arithmetic shift gives round-half-up.
            biased_d = sum_q + (sext_out(bias_q) <<< FRAC_SHIFT) + RND_HALF;
        end
    end

    always_comb begin
        q_full    = biased_q >>> FRAC_SHIFT;
        q_sat     = q_full[OUT_W-1:0];
        q_clamped = 1'b0;
        if (q_full > sext_out(OUT_MAX)) begin
            q_sat     = OUT_MAX;
            q_clamped = 1'b1;
        end else if (q_full < sext_out(OUT_MIN)) begin
            q_sat     = OUT_MIN;
            q_clamped = 1'b1;
        end
        // ReLU acts after saturation and leaves the clamp flag as it was.
        if (RELU_EN && q_sat[OUT_W-1]) begin
            q_sat = '0;
        end
        s3_vld_d = s2_vld_q;
        res_d    = res_q;
        if (s2_vld_q) begin
            res_d.dat = q_sat;
            res_d.sat = q_clamped;
        end
    end

    always_comb begin
        fifo_pop = ~fifo_empty & io.out_ready;
        ovf_d    = ovf_q | (s3_vld_q & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            sum_q    <= '0;
            bias_q   <= '0;
            s1_vld_q <= 1'b0;
            biased_q <= '0;
            s2_vld_q <= 1'b0;
            res_q    <= '0;
            s3_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            bias_q   <= bias_d;
            s1_vld_q <= s1_vld_d;
            biased_q <= biased_d;
            s2_vld_q <= s2_vld_d;
            res_q    <= res_d;
            s3_vld_q <= s3_vld_d;
            ovf_q    <= ovf_d;
        end
    end

    result_fifo #(
        .W ($bits(res_t))
    ) u_result_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (s3_vld_q),
        .push_dat (res_q),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head)
    );

    assign io.out_data  = head.dat;
    assign io.out_sat   = head.sat;
    assign io.out_valid = ~fifo_empty;
    assign io.ovf_err   = ovf_q;

endmodule

// File: tb/tb_mac_accum.sv
// Purpose: scoreboard bench for mac_accum; two instances (ReLU off / on) see identical stimulus.
// Latency: checks the last-tap -> out_valid delay of three cycles.
// Backpressure: exercises out_ready low, buffer overflow and drain order.
module tb_mac_accum;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_accum_if if_a ();  // RELU_EN = 0
    mac_accum_if if_b ();  // RELU_EN = 1

    mac_accum #(.RELU_EN(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .io(if_a.slave));
    mac_accum #(.RELU_EN(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .io(if_b.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // expected {sat, data}
    logic [32:0] q_a[$];
    logic [32:0] q_b[$];

    localparam logic [63:0] P_ONE = 64'h0000_0001_0000_0000;  // 1.0 x 1.0 in Q32.32

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_both(input logic sat_a, input logic [31:0] dat_a,
                               input logic sat_b, input logic [31:0] dat_b);
        q_a.push_back({sat_a, dat_a});
        q_b.push_back({sat_b, dat_b});
    endtask

    task automatic set_ready(input logic r);
        if_a.out_ready = r;
        if_b.out_ready = r;
    endtask

    task automatic send_tap(input logic [63:0] p, input logic last, input logic [31:0] b);
        if_a.prod = p;  if_b.prod = p;
        if_a.bias = b;  if_b.bias = b;
        if_a.prod_last  = last; if_b.prod_last  = last;
        if_a.prod_valid = 1'b1; if_b.prod_valid = 1'b1;
        @(posedge clk); #1;
        if_a.prod_valid = 1'b0; if_b.prod_valid = 1'b0;
        if_a.prod_last  = 1'b0; if_b.prod_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitors: pop and compare on every accepted output beat.
    always @(negedge clk) begin
        if (rst_n && if_a.out_valid && if_a.out_ready) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_unexpected: got 0x%0h, expected no output", {if_a.out_sat, if_a.out_data});
            end else begin
                chk("a_out", 64'({if_a.out_sat, if_a.out_data}), 64'(q_a.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_b.out_valid && if_b.out_ready) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected: got 0x%0h, expected no output", {if_b.out_sat, if_b.out_data});
            end else begin
                chk("b_out", 64'({if_b.out_sat, if_b.out_data}), 64'(q_b.pop_front()));
            end
        end
    end

    // Single-tap directed vectors: prod, expected {sat,data} for ReLU off and on.
    localparam int NV = 6;
    logic [63:0] v_prod [NV] = '{
        64'hFFFF_FFFF_0000_0000,   // -1.0
        64'h0000_0000_0000_8000,   // +half LSB -> rounds up
        64'hFFFF_FFFF_FFFF_8000,   // -half LSB -> rounds to 0
        64'h0000_0000_0000_7FFF,   // just under half -> 0
        64'h7FFF_FFFF_FFFF_FFFF,   // positive overflow
        64'h8000_0000_0000_0000    // negative overflow
    };
    logic [32:0] v_exp_a [NV] = '{
        {1'b0, 32'hFFFF_0000}, {1'b0, 32'h0000_0001}, {1'b0, 32'h0000_0000},
        {1'b0, 32'h0000_0000}, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000}
    };
    logic [32:0] v_exp_b [NV] = '{
        {1'b0, 32'h0000_0000}, {1'b0, 32'h0000_0001}, {1'b0, 32'h0000_0000},
        {1'b0, 32'h0000_0000}, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h0000_0000}
    };

    initial begin
        if_a.prod = '0; if_b.prod = '0;
        if_a.bias = '0; if_b.bias = '0;
        if_a.prod_valid = 1'b0; if_b.prod_valid = 1'b0;
        if_a.prod_last  = 1'b0; if_b.prod_last  = 1'b0;
        set_ready(1'b0);

        // Reset state
        idle(2);
        chk("rst_a_data",  64'(if_a.out_data),  64'd0);
        chk("rst_a_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_a_sat",   64'(if_a.out_sat),   64'd0);
        chk("rst_a_ovf",   64'(if_a.ovf_err),   64'd0);
        chk("rst_b_valid", 64'(if_b.out_valid), 64'd0);
        chk("rst_b_ovf",   64'(if_b.ovf_err),   64'd0);
        rst_n = 1'b1;
        idle(1);

        // 25-tap window of 1.0, zero bias -> 25.0; also check the 3-cycle latency
        set_ready(1'b1);
        expect_both(1'b0, 32'd1638400, 1'b0, 32'd1638400);
        for (int i = 0; i < 25; i++) send_tap(P_ONE, i == 24, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_a_T+%0d", k), 64'(if_a.out_valid), 64'(k == 3));
            chk($sformatf("lat_b_T+%0d", k), 64'(if_b.out_valid), 64'(k == 3));
        end
        idle(3);

        // Same window with unit bias and idle gaps inside the frame -> 26.0
        expect_both(1'b0, 32'd1703936, 1'b0, 32'd1703936);
        for (int i = 0; i < 25; i++) begin
            send_tap(P_ONE, i == 24, (i == 24) ? 32'd65536 : 32'hDEAD_BEEF);
            if (i % 7 == 3) idle(1);
        end
        idle(6);

        // Back-to-back single-tap frames: ReLU, rounding, saturation
        for (int i = 0; i < NV; i++) begin
            expect_both(v_exp_a[i][32], v_exp_a[i][31:0], v_exp_b[i][32], v_exp_b[i][31:0]);
            send_tap(v_prod[i], 1'b1, 32'd0);
        end
        idle(8);

        // Backpressure: three results into a 2-entry buffer -> third dropped
        set_ready(1'b0);
        expect_both(1'b0, 32'd65536,  1'b0, 32'd65536);
        expect_both(1'b0, 32'd131072, 1'b0, 32'd131072);
        send_tap(64'd65536  << 16, 1'b1, 32'd0);
        send_tap(64'd131072 << 16, 1'b1, 32'd0);
        send_tap(64'd196608 << 16, 1'b1, 32'd0);
        idle(5);
        chk("ovf_a", 64'(if_a.ovf_err), 64'd1);
        chk("ovf_b", 64'(if_b.ovf_err), 64'd1);
        chk("full_valid_a", 64'(if_a.out_valid), 64'd1);
        set_ready(1'b1);
        idle(4);
        chk("drained_a", 64'(if_a.out_valid), 64'd0);
        chk("ovf_sticky_a", 64'(if_a.ovf_err), 64'd1);

        // Mid-frame reset with a result parked in the buffer
        set_ready(1'b0);
        send_tap(P_ONE, 1'b1, 32'd0);
        send_tap(P_ONE * 5, 1'b0, 32'd0);
        send_tap(P_ONE * 5, 1'b0, 32'd0);
        idle(4);
        chk("parked_a", 64'(if_a.out_valid), 64'd1);
        send_tap(P_ONE * 5, 1'b0, 32'd0);
        rst_n = 1'b0;
        idle(1);
        chk("rst2_a_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst2_b_valid", 64'(if_b.out_valid), 64'd0);
        chk("rst2_a_ovf",   64'(if_a.ovf_err),   64'd0);
        chk("rst2_b_ovf",   64'(if_b.ovf_err),   64'd0);
        rst_n = 1'b1;
        set_ready(1'b1);
        idle(1);
        expect_both(1'b0, 32'd65536, 1'b0, 32'd65536);
        send_tap(P_ONE, 1'b1, 32'd0);

        // Bounded drain of the scoreboard
        for (int t = 0; t < 50 && (q_a.size() != 0 || q_b.size() != 0); t++) idle(1);
        chk("left_a", 64'(q_a.size()), 64'd0);
        chk("left_b", 64'(q_b.size()), 64'd0);
        chk("end_ovf_a", 64'(if_a.ovf_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
